dpram_fifo_ctrl: RTL and testbench
==================================

// Module: dpram_fifo_ctrl
// PURPOSE
//  Synchronous FIFO controller that sits directly upstream of dpram_r2w1 and owns both of its ports.
//  Port A is the write port and port B is the read port; port B's write path is tied off.
//  Converts a valid/ready input stream into RAM writes, and prefetches RAM reads into a 2-entry
//  output skid buffer. Result: a first-word-fall-through, full-throughput (1 word/clk) stream.
//  Both RAM clocks (a_clk, b_clk) are tied to clk at integration.
// PARAMETERS
//  ADDR_W   12   RAM address width; RAM depth = 2**ADDR_W words
//  DATA_W   16   word width; must match dpram_r2w1 data width
// PORTS
//  clk          in   1        single clock for all state; also drives ram a_clk/b_clk
//  reset_n      in   1        asynchronous, active-low reset
//  flush        in   1        synchronous clear of all contents (pointers, buffer, pending read)
//  in_valid     in   1        upstream word valid
//  in_ready     out  1        controller can accept the word (not full)
//  in_data      in   DATA_W   upstream word
//  out_valid    out  1        head word valid
//  out_ready    in   1        downstream accepts head word
//  out_data     out  DATA_W   head word (first-word-fall-through)
//  level        out  ADDR_W+2 words held: RAM + pending read + skid buffer
//  ram_a_we     out  1        to dpram_r2w1 a_we
//  ram_a_ce     out  1        to a_ce
//  ram_a_addr   out  ADDR_W   to a_addr (write pointer)
//  ram_a_write  out  DATA_W   to a_write
//  ram_b_we     out  1        to b_we; constant 0
//  ram_b_ce     out  1        to b_ce (read issue)
//  ram_b_addr   out  ADDR_W   to b_addr (read pointer)
//  ram_b_write  out  DATA_W   to b_write; constant 0
//  ram_b_read   in   DATA_W   from b_read; valid in the cycle after a read issue (1-clk sync read)
// BEHAVIOUR
//  Reset (async on reset_n low; flush has the same effect at the next edge):
//   - wr_ptr = 0, rd_ptr = 0, ram_cnt = 0, rd_pend = 0, buf_cnt = 0.
//   - out_valid = 0, level = 0, all RAM ce/we = 0.
//   - in_ready = 0 while reset_n is low; in_ready = 1 after release.
//  Write path:
//   - push = in_valid & in_ready.
//   - On push: ram_a_we = ram_a_ce = 1, ram_a_addr = wr_ptr, ram_a_write = in_data (combinational).
//   - wr_ptr increments at the edge and wraps 2**ADDR_W-1 -> 0.
//   - in_ready = (level < 2**ADDR_W), registered-state based.
//  Read issue:
//   - rd = (ram_cnt > 0) & (buf_cnt + rd_pend - pop < 2).
//   - On rd: ram_b_ce = 1, ram_b_addr = rd_ptr; rd_ptr increments with wrap; rd_pend <= 1.
//   - ram_cnt counts only words written at prior edges, so a read never targets the address
//     written in the same cycle (no read-during-write collision).
//  Return path:
//   - When rd_pend = 1, ram_b_read is captured into the skid buffer at the edge; rd_pend <= rd.
//  Output:
//   - out_valid = (buf_cnt > 0); out_data = skid head.
//   - pop = out_valid & out_ready.
//   - Simultaneous capture and pop are legal; buf_cnt is unchanged in that case.
//  Counters:
//   - ram_cnt' = ram_cnt + push - rd.
//   - level = ram_cnt + rd_pend + buf_cnt (ADDR_W+2 bits, no overflow).
//   - Simultaneous push and pop at full: pop frees a slot only at the next edge; in_ready stays 0
//     this cycle.
//  Latency: word accepted at edge E0 -> read issued during cycle E0..E1 -> captured at E2 ->
//   out_valid high after E2 (2 clk, empty FIFO). Sustained 1 word/clk with out_ready held high.
//  Capacity: 2**ADDR_W words total, including the skid buffer.
//   - Once the skid buffer fills, the RAM holds at most 2**ADDR_W-2 words, so ram_cnt never
//     exceeds depth.
//  Mid-operation reset/flush: a pending RAM read result is discarded, and the next word after
//   release is read from address 0.
// STRUCTURE
//  Shared package fifo_pkg:
//   - localparam DEPTH = 2**ADDR_W.
//   - SKID_DEPTH = 2.
//   - RD_LAT = 1, the RAM read latency used in the issue rule.
//  Sub-module fifo_skid2:
//   - 2-entry output buffer with push/pop and count.
//   - Instantiated once; everything else is flat in this module.
// TESTING
//  1. Reset, then push 0x1234 once (out_ready = 0) -> out_valid rises 2 clk after accept;
//     out_data = 0x1234; level = 1.
//  2. Stream 0x0000..0x00FF with in_valid/out_ready held high -> after 2 clk, 1 word/clk out in
//     order; in_ready never drops.
//  3. ADDR_W = 4, out_ready = 0, push 20 words -> in_ready drops after 16 accepted; level = 16;
//     words 17..20 held off.
//  4. Full, then out_ready = 1 and in_valid = 1 -> 16 words out in order; refill continues;
//     wr_ptr/rd_ptr wrap 15 -> 0 without corruption.
//  5. Random in_valid/out_ready (50%), 10k words -> scoreboard exact order; level always equals
//     pushed minus popped.
//  6. Assert reset_n low, then separately flush, with a read pending and 5 words stored ->
//     out_valid = 0, level = 0 next cycle; the next push returns the new word, not stale data.

Source files
------------

// File: rtl/dpram_fifo_ctrl_pkg.sv
// fifo_pkg: shared constants for the dual-port-RAM FIFO controller and its skid buffer.
package fifo_pkg;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 16;
    localparam int DEPTH      = 2 ** DEF_ADDR_W;
    localparam int SKID_DEPTH = 2;
    localparam int RD_LAT     = 1;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// dpram_fifo_ctrl_if: valid/ready word stream; master drives valid/data, slave drives ready.
interface dpram_fifo_ctrl_if #(parameter int DATA_W = 16);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dpram_fifo_ctrl_skid.sv
// fifo_skid2: two-entry output buffer; e0 is always the head, e1 the word behind it.
module fifo_skid2
    import fifo_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        cnt
);
    logic [DATA_W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]        cnt_q, cnt_d;

    always_comb begin
        cnt_d = flush ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
        e0_d  = pop ? ((cnt_q == 2'(SKID_DEPTH)) ? e1_q : push_data)
                    : ((push && cnt_q == 2'd0) ? push_data : e0_q);
        e1_d  = (push && (cnt_q - 2'(pop)) == 2'd1) ? push_data : e1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    assign valid = cnt_q != 2'd0;
    assign head  = e0_q;
    assign cnt   = cnt_q;
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: drives both ports of dpram_r2w1 as a FIFO (A writes, B reads) and
// prefetches into a 2-entry skid so the output is first-word-fall-through at 1 word/clk.
module dpram_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    dpram_fifo_ctrl_if.slave    in_s,
    dpram_fifo_ctrl_if.master   out_m,
    output logic [ADDR_W+1:0]   level,
    output logic                ram_a_we,
    output logic                ram_a_ce,
    output logic [ADDR_W-1:0]   ram_a_addr,
    output logic [DATA_W-1:0]   ram_a_write,
    output logic                ram_b_we,
    output logic                ram_b_ce,
    output logic [ADDR_W-1:0]   ram_b_addr,
    output logic [DATA_W-1:0]   ram_b_write,
    input  logic [DATA_W-1:0]   ram_b_read
);
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic [1:0]        buf_cnt;
    logic              push, pop, rd;

    always_comb begin
        level      = (ADDR_W+2)'(ram_cnt_q) + (ADDR_W+2)'(rd_pend_q) + (ADDR_W+2)'(buf_cnt);
        in_s.ready = reset_n && (level < (ADDR_W+2)'(depth(ADDR_W)));
        push       = in_s.valid && in_s.ready;
        pop        = out_m.valid && out_m.ready;
        // only issue when the word still has a skid slot by the time it returns
        rd         = (ram_cnt_q != '0) &&
                     (({1'b0, buf_cnt} + 3'(rd_pend_q) - 3'(pop)) < 3'(SKID_DEPTH));
        wr_ptr_d   = flush ? '0 : wr_ptr_q + ADDR_W'(push);
        rd_ptr_d   = flush ? '0 : rd_ptr_q + ADDR_W'(rd);
        ram_cnt_d  = flush ? '0 : ram_cnt_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(rd);
        rd_pend_d  = !flush && rd;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign ram_a_we    = push;
    assign ram_a_ce    = push;
    assign ram_a_addr  = wr_ptr_q;
    assign ram_a_write = in_s.data;
    assign ram_b_we    = 1'b0;
    assign ram_b_ce    = rd;
    assign ram_b_addr  = rd_ptr_q;
    assign ram_b_write = '0;

    fifo_skid2 #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (rd_pend_q),
        .push_data (ram_b_read),
        .pop       (pop),
        .valid     (out_m.valid),
        .head      (out_m.data),
        .cnt       (buf_cnt)
    );
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl: directed bench for dpram_fifo_ctrl (ADDR_W=4) with a behavioural 1-clk RAM
// and a queue model of the stored words.
module tb_dpram_fifo_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        flush;
    logic [5:0]  level;
    logic        ram_a_we, ram_a_ce, ram_b_we, ram_b_ce;
    logic [3:0]  ram_a_addr, ram_b_addr;
    logic [15:0] ram_a_write, ram_b_write, ram_b_read;
    logic [15:0] mem [16];
    logic [15:0] q[$];
    logic [15:0] nxt;
    int          n_chk, n_err, n_pop, n_push, cnt;
    bit          acc;

    dpram_fifo_ctrl_if #(.DATA_W(16)) in_s ();
    dpram_fifo_ctrl_if #(.DATA_W(16)) out_m ();

    dpram_fifo_ctrl #(.ADDR_W(4), .DATA_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_s(in_s), .out_m(out_m), .level(level),
        .ram_a_we(ram_a_we), .ram_a_ce(ram_a_ce), .ram_a_addr(ram_a_addr), .ram_a_write(ram_a_write),
        .ram_b_we(ram_b_we), .ram_b_ce(ram_b_ce), .ram_b_addr(ram_b_addr), .ram_b_write(ram_b_write),
        .ram_b_read(ram_b_read)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_a_ce && ram_a_we) mem[ram_a_addr] <= ram_a_write;
        if (ram_b_ce) ram_b_read <= mem[ram_b_addr];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("level", 32'(level), 32'(q.size()));
        acc = in_s.valid && in_s.ready;
        if (out_m.valid && out_m.ready) begin
            n_pop++;
            if (q.size() == 0) chk("pop_unexpected", 32'(out_m.valid), 32'd0);
            else chk("data", 32'(out_m.data), 32'(q.pop_front()));
        end
        if (acc) begin
            q.push_back(in_s.data);
            n_push++;
        end
        if (flush) q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q.delete();
        #1;
        chk("rst_in_ready", 32'(in_s.ready), 32'd0);
        chk("rst_out_valid", 32'(out_m.valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_a_we", 32'(ram_a_we), 32'd0);
        chk("rst_b_ce", 32'(ram_b_ce), 32'd0);
        chk("rst_b_we", 32'(ram_b_we), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_s.ready), 32'd1);
    endtask

    task automatic drain(input int max);
        out_m.ready = 1'b1;
        in_s.valid = 1'b0;
        for (int i = 0; i < max && q.size() > 0; i++) tick();
        chk("drain_empty", 32'(q.size()), 32'd0);
        chk("drain_out_valid", 32'(out_m.valid), 32'd0);
    endtask

    task automatic fill_pend();
        out_m.ready = 1'b0;
        in_s.valid = 1'b1;
        repeat (6) begin
            in_s.data = nxt;
            tick();
            nxt++;
        end
        in_s.valid = 1'b0;
        repeat (3) tick();
        out_m.ready = 1'b1;
        tick();
        out_m.ready = 1'b0;
        chk("t6_level5", 32'(level), 32'd5);
    endtask

    task automatic new_word(input logic [15:0] w);
        in_s.valid = 1'b1;
        in_s.data = w;
        #1;
        chk("t6_a_addr0", 32'(ram_a_addr), 32'd0);
        tick();
        in_s.valid = 1'b0;
        chk("t6_b_addr0", 32'(ram_b_addr), 32'd0);
        repeat (2) tick();
        chk("t6_new_valid", 32'(out_m.valid), 32'd1);
        chk("t6_new_data", 32'(out_m.data), 32'(w));
        drain(8);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        flush = 1'b0;
        in_s.valid = 1'b0;
        in_s.data = '0;
        out_m.ready = 1'b0;
        #2;
        do_reset();
        // 1: single word latency
        in_s.valid = 1'b1;
        in_s.data = 16'h1234;
        #1;
        chk("t1_a_we", 32'(ram_a_we), 32'd1);
        chk("t1_a_addr", 32'(ram_a_addr), 32'd0);
        chk("t1_a_write", 32'(ram_a_write), 32'h1234);
        tick();
        in_s.valid = 1'b0;
        chk("t1_ov_e0", 32'(out_m.valid), 32'd0);
        chk("t1_b_ce", 32'(ram_b_ce), 32'd1);
        tick();
        chk("t1_ov_e1", 32'(out_m.valid), 32'd0);
        tick();
        chk("t1_ov_e2", 32'(out_m.valid), 32'd1);
        chk("t1_data", 32'(out_m.data), 32'h1234);
        chk("t1_level", 32'(level), 32'd1);
        drain(8);
        // 2: full-rate stream
        do_reset();
        in_s.valid = 1'b1;
        out_m.ready = 1'b1;
        n_pop = 0;
        nxt = 16'h0000;
        for (int i = 0; i < 300 && nxt < 16'd256; i++) begin
            in_s.data = nxt;
            #1;
            chk("t2_in_ready", 32'(in_s.ready), 32'd1);
            tick();
            if (acc) nxt++;
        end
        chk("t2_pops", 32'(n_pop), 32'd253);
        drain(10);
        chk("t2_total", 32'(n_pop), 32'd256);
        // 3: fill to capacity
        do_reset();
        out_m.ready = 1'b0;
        in_s.valid = 1'b1;
        nxt = 16'h0100;
        cnt = 0;
        repeat (20) begin
            in_s.data = nxt;
            tick();
            if (acc) begin
                nxt++;
                cnt++;
            end
        end
        chk("t3_accepted", 32'(cnt), 32'd16);
        chk("t3_level", 32'(level), 32'd16);
        chk("t3_in_ready", 32'(in_s.ready), 32'd0);
        chk("t3_head", 32'(out_m.data), 32'h0100);
        // 4: drain from full while refilling; pointers wrap
        out_m.ready = 1'b1;
        in_s.data = nxt;
        #1;
        chk("t4_in_ready_full", 32'(in_s.ready), 32'd0);
        repeat (48) begin
            in_s.data = nxt;
            tick();
            if (acc) nxt++;
        end
        chk("t4_words", 32'(nxt - 16'h0100), 32'd63);
        drain(40);
        // 5: random handshakes
        do_reset();
        n_push = 0;
        for (int i = 0; i < 60000 && n_push < 10000; i++) begin
            in_s.valid = 1'($urandom_range(0, 1));
            out_m.ready = 1'($urandom_range(0, 1));
            in_s.data = 16'($urandom);
            tick();
        end
        chk("t5_pushed", 32'(n_push), 32'd10000);
        drain(100);
        // 6a: async reset with a read pending
        do_reset();
        nxt = 16'h0a00;
        fill_pend();
        do_reset();
        tick();
        chk("t6r_no_stale", 32'(out_m.valid), 32'd0);
        new_word(16'hbeef);
        // 6b: flush with a read pending
        do_reset();
        nxt = 16'h0b00;
        fill_pend();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6f_out_valid", 32'(out_m.valid), 32'd0);
        chk("t6f_level", 32'(level), 32'd0);
        tick();
        chk("t6f_no_stale", 32'(out_m.valid), 32'd0);
        new_word(16'hcafe);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
